// File: rtl/ttt_pkg.sv
// rtl/ttt_pkg.sv - shared cell encodings, FSM state enum and board-index helper
package ttt_pkg;

    localparam logic [1:0] EMPTY    = 2'b00;
    localparam logic [1:0] PLAYER   = 2'b01;
    localparam logic [1:0] COMPUTER = 2'b10;

    typedef enum logic [1:0] {
        WAIT_PL = 2'd0,
        WAIT_PC = 2'd1,
        FULL    = 2'd2
    } state_t;

    // Cell i occupies board bits [2i+1:2i].
    function automatic int cell_lsb(input int idx);
        return 2 * idx;
    endfunction

endpackage

// File: rtl/move_validator_if.sv
// rtl/move_validator_if.sv - move request / board status bundle for move_validator
interface move_validator_if #(
    parameter int N     = 3,
    parameter int CNT_W = 4
);
    localparam int CELLS = N * N;

    logic                 clear;
    logic                 move_valid;
    logic                 move_ready;
    logic [CELLS-1:0]     pl_en;
    logic [CELLS-1:0]     pc_en;
    logic [2*CELLS-1:0]   board;
    logic                 turn;
    logic                 move_accepted;
    logic                 illegal_move;
    logic                 board_full;
    logic [CNT_W-1:0]     illegal_cnt;

    modport master (
        output clear, move_valid, pl_en, pc_en,
        input  move_ready, board, turn, move_accepted, illegal_move, board_full, illegal_cnt
    );

    modport slave (
        input  clear, move_valid, pl_en, pc_en,
        output move_ready, board, turn, move_accepted, illegal_move, board_full, illegal_cnt
    );

endinterface

// File: rtl/onehot_check.sv
// rtl/onehot_check.sv - flags a vector as exactly one-hot and/or all-zero
module onehot_check #(
    parameter int W = 9
) (
    input  logic [W-1:0] vec,
    output logic         is_onehot,
    output logic         is_zero
);

    always_comb begin
        is_zero   = (vec == '0);
        // Clearing the lowest set bit leaves zero only for a single set bit.
        is_onehot = !is_zero && ((vec & (vec - W'(1))) == '0);
    end

endmodule

// File: rtl/move_validator.sv
// rtl/move_validator.sv - tic-tac-toe move legality checker, board store and turn FSM
module move_validator
    import ttt_pkg::*;
#(
    parameter int N     = 3,
    parameter int CNT_W = 4
) (
    input  logic             clock,
    input  logic             reset,
    move_validator_if.slave  bus
);

    localparam int CELLS = N * N;

    state_t               state_q, state_d;
    logic [2*CELLS-1:0]   board_q, board_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 acc_q, acc_d;
    logic                 ill_q, ill_d;
    logic                 full_q, full_d;

    logic [CELLS-1:0]     occ_q, occ_d, sel_en;
    logic                 pl_onehot, pl_zero, pc_onehot, pc_zero;
    logic                 handshake, legal, write_en;
    logic [1:0]           mark;

    onehot_check #(.W(CELLS)) u_pl_check (
        .vec       (bus.pl_en),
        .is_onehot (pl_onehot),
        .is_zero   (pl_zero)
    );

    onehot_check #(.W(CELLS)) u_pc_check (
        .vec       (bus.pc_en),
        .is_onehot (pc_onehot),
        .is_zero   (pc_zero)
    );

    always_comb begin
        handshake = bus.move_valid && (state_q != FULL);
        sel_en    = (state_q == WAIT_PC) ? bus.pc_en : bus.pl_en;
        mark      = (state_q == WAIT_PC) ? COMPUTER : PLAYER;
        if (state_q == WAIT_PC) begin
            legal = pc_onehot && pl_zero;
        end else begin
            legal = pl_onehot && pc_zero;
        end
        // With a one-hot select, the cell is empty iff it misses every occupied bit.
        legal    = legal && ((sel_en & occ_q) == '0);
        write_en = handshake && legal && !bus.clear;
    end

    for (genvar i = 0; i < CELLS; i++) begin : g_cell
        assign occ_q[i] = |board_q[cell_lsb(i) +: 2];
        assign board_d[cell_lsb(i) +: 2] = bus.clear                ? EMPTY :
                                           (write_en && sel_en[i])  ? mark  :
                                           board_q[cell_lsb(i) +: 2];
        assign occ_d[i] = |board_d[cell_lsb(i) +: 2];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = 1'b0;
        ill_d   = 1'b0;
        full_d  = &occ_d;
        if (bus.clear) begin
            state_d = WAIT_PL;
            cnt_d   = '0;
        end else if (handshake) begin
            if (legal) begin
                acc_d = 1'b1;
                if (&occ_d) begin
                    state_d = FULL;
                end else begin
                    state_d = (state_q == WAIT_PL) ? WAIT_PC : WAIT_PL;
                end
            end else begin
                ill_d = 1'b1;
                if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= WAIT_PL;
            board_q <= '0;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
            ill_q   <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            board_q <= board_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            ill_q   <= ill_d;
            full_q  <= full_d;
        end
    end

    assign bus.move_ready    = (state_q != FULL);
    assign bus.turn          = (state_q == WAIT_PC);
    assign bus.board         = board_q;
    assign bus.move_accepted = acc_q;
    assign bus.illegal_move  = ill_q;
    assign bus.board_full    = full_q;
    assign bus.illegal_cnt   = cnt_q;

endmodule

// File: tb/tb_move_validator.sv
// tb/tb_move_validator.sv - directed self-checking bench for move_validator
module tb_move_validator;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic rst_c = 1'b1;

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    move_validator_if #(.N(3), .CNT_W(4)) ifa ();
    move_validator_if #(.N(3), .CNT_W(2)) ifb ();
    move_validator_if #(.N(4), .CNT_W(4)) ifc ();

    move_validator #(.N(3), .CNT_W(4)) dut_a (.clock(clock), .reset(reset), .bus(ifa));
    move_validator #(.N(3), .CNT_W(2)) dut_b (.clock(clock), .reset(reset), .bus(ifb));
    move_validator #(.N(4), .CNT_W(4)) dut_c (.clock(clock), .reset(rst_c), .bus(ifc));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic drive_a(input logic v, input logic [8:0] pl, input logic [8:0] pc, input logic clr);
        ifa.move_valid = v; ifa.pl_en = pl; ifa.pc_en = pc; ifa.clear = clr;
        @(posedge clock); #1;
        ifa.move_valid = 1'b0; ifa.pl_en = '0; ifa.pc_en = '0; ifa.clear = 1'b0;
    endtask

    task automatic drive_b(input logic v, input logic [8:0] pl, input logic [8:0] pc, input logic clr);
        ifb.move_valid = v; ifb.pl_en = pl; ifb.pc_en = pc; ifb.clear = clr;
        @(posedge clock); #1;
        ifb.move_valid = 1'b0; ifb.pl_en = '0; ifb.pc_en = '0; ifb.clear = 1'b0;
    endtask

    task automatic drive_c(input logic v, input logic [15:0] pl, input logic [15:0] pc);
        ifc.move_valid = v; ifc.pl_en = pl; ifc.pc_en = pc; ifc.clear = 1'b0;
        @(posedge clock); #1;
        ifc.move_valid = 1'b0; ifc.pl_en = '0; ifc.pc_en = '0;
    endtask

    logic [8:0]  bad_pl [3] = '{9'h003, 9'h000, 9'h004};
    logic [8:0]  bad_pc [3] = '{9'h000, 9'h000, 9'h004};
    logic [17:0] exp_board;
    logic [8:0]  sel;

    initial begin
        ifa.move_valid = 1'b0; ifa.pl_en = '0; ifa.pc_en = '0; ifa.clear = 1'b0;
        ifb.move_valid = 1'b0; ifb.pl_en = '0; ifb.pc_en = '0; ifb.clear = 1'b0;
        ifc.move_valid = 1'b0; ifc.pl_en = '0; ifc.pc_en = '0; ifc.clear = 1'b0;

        @(posedge clock); #1;
        check("rst_board", ifa.board, 0);
        check("rst_turn", ifa.turn, 0);
        check("rst_acc", ifa.move_accepted, 0);
        check("rst_ill", ifa.illegal_move, 0);
        check("rst_full", ifa.board_full, 0);
        check("rst_cnt", ifa.illegal_cnt, 0);
        check("rst_ready", ifa.move_ready, 1);
        @(posedge clock); #1;
        reset = 1'b0;
        rst_c = 1'b0;

        // First legal player move into cell 0
        drive_a(1'b1, 9'h001, 9'h000, 1'b0);
        check("p1_acc", ifa.move_accepted, 1);
        check("p1_ill", ifa.illegal_move, 0);
        check("p1_board", ifa.board, 18'h00001);
        check("p1_turn", ifa.turn, 1);
        drive_a(1'b0, 9'h000, 9'h000, 1'b0);
        check("p1_pulse_end", ifa.move_accepted, 0);

        // Computer tries occupied cell 0
        drive_a(1'b1, 9'h000, 9'h001, 1'b0);
        check("occ_ill", ifa.illegal_move, 1);
        check("occ_acc", ifa.move_accepted, 0);
        check("occ_board", ifa.board, 18'h00001);
        check("occ_cnt", ifa.illegal_cnt, 1);
        check("occ_turn", ifa.turn, 1);

        drive_a(1'b1, 9'h000, 9'h002, 1'b0);
        check("c1_acc", ifa.move_accepted, 1);
        check("c1_board", ifa.board, 18'h00009);
        check("c1_turn", ifa.turn, 0);

        drive_a(1'b0, 9'h000, 9'h000, 1'b1);
        check("clr_board", ifa.board, 0);
        check("clr_cnt", ifa.illegal_cnt, 0);
        check("clr_turn", ifa.turn, 0);

        // Malformed player requests, back to back
        for (int k = 0; k < 3; k++) begin
            drive_a(1'b1, bad_pl[k], bad_pc[k], 1'b0);
            check($sformatf("bad%0d_ill", k), ifa.illegal_move, 1);
            check($sformatf("bad%0d_acc", k), ifa.move_accepted, 0);
            check($sformatf("bad%0d_cnt", k), ifa.illegal_cnt, k + 1);
        end
        check("bad_board", ifa.board, 0);
        check("bad_turn", ifa.turn, 0);

        // Fill the board with nine alternating moves
        exp_board = '0;
        for (int k = 0; k < 9; k++) begin
            sel = 9'h001 << k;
            if (k % 2 == 0) begin
                drive_a(1'b1, sel, 9'h000, 1'b0);
                exp_board[2*k +: 2] = 2'b01;
            end else begin
                drive_a(1'b1, 9'h000, sel, 1'b0);
                exp_board[2*k +: 2] = 2'b10;
            end
            check($sformatf("fill%0d_acc", k), ifa.move_accepted, 1);
            check($sformatf("fill%0d_board", k), ifa.board, exp_board);
            check($sformatf("fill%0d_full", k), ifa.board_full, (k == 8) ? 1 : 0);
            check($sformatf("fill%0d_ready", k), ifa.move_ready, (k == 8) ? 0 : 1);
            check($sformatf("fill%0d_turn", k), ifa.turn, (k % 2 == 0 && k != 8) ? 1 : 0);
        end
        drive_a(1'b1, 9'h001, 9'h000, 1'b0);
        check("full_acc", ifa.move_accepted, 0);
        check("full_ill", ifa.illegal_move, 0);
        check("full_cnt", ifa.illegal_cnt, 3);
        check("full_board", ifa.board, exp_board);
        check("full_stays", ifa.board_full, 1);
        drive_a(1'b0, 9'h000, 9'h000, 1'b1);
        check("full_clr_full", ifa.board_full, 0);
        check("full_clr_ready", ifa.move_ready, 1);

        // Narrow counter saturation, then clear beating a legal move
        drive_b(1'b1, 9'h001, 9'h000, 1'b0);
        check("b_p1_board", ifb.board, 18'h00001);
        for (int k = 1; k <= 5; k++) begin
            drive_b(1'b1, 9'h000, 9'h000, 1'b0);
            check($sformatf("b_ill%0d", k), ifb.illegal_move, 1);
            check($sformatf("b_cnt%0d", k), ifb.illegal_cnt, (k > 3) ? 3 : k);
        end
        drive_b(1'b1, 9'h000, 9'h002, 1'b1);
        check("b_clr_board", ifb.board, 0);
        check("b_clr_cnt", ifb.illegal_cnt, 0);
        check("b_clr_acc", ifb.move_accepted, 0);
        check("b_clr_ill", ifb.illegal_move, 0);
        check("b_clr_turn", ifb.turn, 0);

        // N=4: reset lands on a legal computer handshake
        drive_c(1'b1, 16'h0001, 16'h0000);
        check("c_p1_acc", ifc.move_accepted, 1);
        check("c_p1_board", ifc.board, 32'h0000_0001);
        check("c_p1_turn", ifc.turn, 1);
        ifc.move_valid = 1'b1; ifc.pc_en = 16'h0002; rst_c = 1'b1;
        @(posedge clock); #1;
        check("c_rst_board", ifc.board, 0);
        check("c_rst_ready", ifc.move_ready, 1);
        ifc.move_valid = 1'b0; ifc.pc_en = '0; rst_c = 1'b0;
        @(posedge clock); #1;
        check("c_post_acc", ifc.move_accepted, 0);
        check("c_post_ill", ifc.illegal_move, 0);
        check("c_post_board", ifc.board, 0);
        check("c_post_turn", ifc.turn, 0);
        drive_c(1'b1, 16'h8000, 16'h0000);
        check("c_p15_acc", ifc.move_accepted, 1);
        check("c_p15_board", ifc.board, 32'h4000_0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
